// File: rtl/hazard_controller.sv
// Hazard sequencing for the 5-stage core: load-use stall, MUL/DIV freeze with
// a watchdog, and taken-branch flush. All control outputs are combinational.
module hazard_controller #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           id_rs1_addr,
  input  logic [4:0]           id_rs2_addr,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 ex_mem_read,
  input  logic [4:0]           ex_rd_addr,
  input  logic                 ex_mdu_op,
  input  logic                 ex_branch_taken,
  input  logic                 mdu_done,
  output logic                 mdu_start,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 stall_ex,
  output logic                 bubble_ex,
  output logic                 flush_id,
  output logic                 mdu_timeout,
  output logic [CNT_WIDTH-1:0] stall_count
);
  localparam int TW = $clog2(MDU_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MDU_WAIT} state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 timeout_q, timeout_set;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 load_use;
  logic                 start_c, sif_c, sid_c, sex_c, bub_c, flush_c;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use = ex_mem_read && (ex_rd_addr != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                     (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    timeout_set = 1'b0;
    start_c     = 1'b0;
    sif_c       = 1'b0;
    sid_c       = 1'b0;
    sex_c       = 1'b0;
    bub_c       = 1'b0;
    flush_c     = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_mdu_op) begin
          start_c = 1'b1;
          sif_c   = 1'b1;
          sid_c   = 1'b1;
          sex_c   = 1'b1;
          timer_d = '0;
          state_d = MDU_WAIT;
        end else if (ex_branch_taken) begin
          flush_c = 1'b1;
          bub_c   = 1'b1;
        end else if (load_use) begin
          sif_c   = 1'b1;
          sid_c   = 1'b1;
          bub_c   = 1'b1;
          state_d = LOAD_STALL;
        end
      end
      LOAD_STALL: state_d = RUN;
      MDU_WAIT: begin
        timer_d = timer_q + 1'b1;
        if (mdu_done) begin
          state_d = RUN;
        end else if (timer_q == TW'(MDU_TIMEOUT - 1)) begin
          // forced release: let EX advance with whatever it holds and flag it
          state_d     = RUN;
          timeout_set = 1'b1;
        end else begin
          sif_c = 1'b1;
          sid_c = 1'b1;
          sex_c = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (timeout_set) timeout_q <= 1'b1;
      if (sif_c && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Gate with rst_n so outputs fall immediately, even with live EX inputs
  assign mdu_start   = rst_n & start_c;
  assign stall_if    = rst_n & sif_c;
  assign stall_id    = rst_n & sid_c;
  assign stall_ex    = rst_n & sex_c;
  assign bubble_ex   = rst_n & bub_c;
  assign flush_id    = rst_n & flush_c;
  assign mdu_timeout = timeout_q;
  assign stall_count = cnt_q;
endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: single-cycle decode table in RUN plus
// hand-written load-stall, MDU handshake, watchdog, saturation and reset sequences.
module tb_hazard_controller;
  localparam int TO = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    id_rs1_addr = '0, id_rs2_addr = '0, ex_rd_addr = '0;
  logic          id_uses_rs1 = 0, id_uses_rs2 = 0, ex_mem_read = 0;
  logic          ex_mdu_op = 0, ex_branch_taken = 0, mdu_done = 0;
  logic          mdu_start, stall_if, stall_id, stall_ex, bubble_ex, flush_id, mdu_timeout;
  logic [CW-1:0] stall_count;

  int errors = 0;
  int checks = 0;

  hazard_controller #(.MDU_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .ex_mdu_op(ex_mdu_op), .ex_branch_taken(ex_branch_taken), .mdu_done(mdu_done),
    .mdu_start(mdu_start), .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .bubble_ex(bubble_ex), .flush_id(flush_id), .mdu_timeout(mdu_timeout),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // {mdu_start, stall_if, stall_id, stall_ex, bubble_ex, flush_id}
  function automatic logic [5:0] ctl();
    return {mdu_start, stall_if, stall_id, stall_ex, bubble_ex, flush_id};
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1_addr = 0; id_rs2_addr = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_mem_read = 0; ex_rd_addr = 0; ex_mdu_op = 0; ex_branch_taken = 0; mdu_done = 0;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mrd, br;
    logic [5:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[$];

  initial begin
    //              rs1 rs2 rd  u1 u2 mrd br  exp
    tbl.push_back('{5'd0,  5'd0,  5'd0,  0, 0, 0, 0, 6'b000000, "idle"});
    tbl.push_back('{5'd5,  5'd0,  5'd5,  1, 0, 1, 0, 6'b011010, "lu_rs1"});
    tbl.push_back('{5'd0,  5'd0,  5'd0,  1, 1, 1, 0, 6'b000000, "x0_load"});
    tbl.push_back('{5'd0,  5'd5,  5'd5,  0, 0, 1, 0, 6'b000000, "rs2_unused"});
    tbl.push_back('{5'd0,  5'd5,  5'd5,  0, 1, 1, 0, 6'b011010, "lu_rs2"});
    tbl.push_back('{5'd5,  5'd0,  5'd5,  1, 0, 0, 0, 6'b000000, "not_load"});
    tbl.push_back('{5'd5,  5'd0,  5'd5,  1, 0, 1, 1, 6'b000011, "br_over_lu"});
    tbl.push_back('{5'd3,  5'd4,  5'd9,  1, 1, 0, 1, 6'b000011, "br_only"});
    tbl.push_back('{5'd6,  5'd8,  5'd7,  1, 1, 1, 0, 6'b000000, "lu_nomatch"});
    tbl.push_back('{5'd31, 5'd31, 5'd31, 0, 1, 1, 0, 6'b011010, "lu_x31"});

    do_reset();
    chk("rst_ctl", ctl(), 0);
    chk("rst_timeout", mdu_timeout, 0);
    chk("rst_count", stall_count, 0);

    foreach (tbl[i]) begin
      id_rs1_addr = tbl[i].rs1; id_rs2_addr = tbl[i].rs2; ex_rd_addr = tbl[i].rd;
      id_uses_rs1 = tbl[i].u1;  id_uses_rs2 = tbl[i].u2;
      ex_mem_read = tbl[i].mrd; ex_branch_taken = tbl[i].br;
      #1;
      chk(tbl[i].name, ctl(), tbl[i].exp);
      tick();
      idle();
      tick();
    end

    // load-use: stall at N, suppressed at N+1, hazard seen again at N+2
    do_reset();
    ex_mem_read = 1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_uses_rs1 = 1;
    #1;
    chk("ls_N", ctl(), 6'b011010);
    tick();
    chk("ls_N1_suppressed", ctl(), 0);
    tick();
    chk("ls_N2_count", stall_count, 1);
    chk("ls_N2_run", ctl(), 6'b011010);
    idle();
    tick();

    // MDU with done after 5 cycles
    do_reset();
    ex_mdu_op = 1;
    #1;
    chk("mdu_N", ctl(), 6'b111100);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("mdu_N%0d", k), ctl(), 6'b011100);
    end
    tick();
    mdu_done = 1;
    #1;
    chk("mdu_done_release", ctl(), 0);
    tick();
    idle();
    #1;
    chk("mdu_count", stall_count, 5);
    chk("mdu_no_timeout", mdu_timeout, 0);
    chk("mdu_after_ctl", ctl(), 0);

    // watchdog: no done, forced release at N+TO
    do_reset();
    ex_mdu_op = 1;
    #1;
    chk("wd_N", ctl(), 6'b111100);
    for (int k = 1; k < TO; k++) begin
      tick();
      chk($sformatf("wd_N%0d", k), ctl(), 6'b011100);
    end
    tick();
    chk("wd_release", ctl(), 0);
    chk("wd_flag_not_yet", mdu_timeout, 0);
    tick();
    ex_mdu_op = 0;
    #1;
    chk("wd_flag_set", mdu_timeout, 1);
    tick();
    tick();
    tick();
    mdu_done = 1;
    #1;
    chk("wd_late_done", ctl(), 0);
    tick();
    mdu_done = 0;
    chk("wd_sticky", mdu_timeout, 1);
    chk("wd_count", stall_count, TO);

    // second timed-out op pushes stall_count past all-ones
    ex_mdu_op = 1;
    for (int k = 0; k <= TO; k++) tick();
    ex_mdu_op = 0;
    #1;
    chk("sat_count", stall_count, 15);
    ex_mem_read = 1; ex_rd_addr = 5'd2; id_rs2_addr = 5'd2; id_uses_rs2 = 1;
    #1;
    chk("sat_lu", ctl(), 6'b011010);
    tick();
    idle();
    chk("sat_hold", stall_count, 15);
    tick();

    // async reset in the middle of MDU_WAIT
    ex_mdu_op = 1;
    tick();
    tick();
    chk("ar_waiting", ctl(), 6'b011100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ctl", ctl(), 0);
    chk("ar_count", stall_count, 0);
    chk("ar_timeout", mdu_timeout, 0);
    @(negedge clk);
    ex_mdu_op = 0;
    rst_n = 1'b1;
    tick();
    chk("ar_idle", ctl(), 0);
    ex_mdu_op = 1;
    #1;
    chk("ar_restart", ctl(), 6'b111100);
    tick();
    chk("ar_wait_again", ctl(), 6'b011100);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
endmodule
